// File: rtl/booth_r8_frozen_enc.sv
// rtl/booth_r8_frozen_enc.sv - radix-8 Booth operand encoder with frozen, atomically committed outputs
module booth_r8_frozen_enc #(
  parameter int WIDTH  = 16,
  parameter int GROUPS = (WIDTH >> 2) + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [GROUPS-1:0] s,
  output logic [GROUPS-1:0] d,
  output logic [GROUPS-1:0] t,
  output logic [GROUPS-1:0] q,
  output logic [GROUPS-1:0] n,
  output logic [WIDTH-1:0]  my,
  output logic [WIDTH+1:0]  tmy,
  output logic              enc_valid,
  output logic              enc_upd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENC    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  // x extended with x[-1]=0 below and sign copies above, so every group has a full 4-bit window
  localparam int XEW = 3 * GROUPS + 1;
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     g_q, g_d;
  logic [WIDTH-1:0]  xs_q, xs_d;
  logic [WIDTH-1:0]  ys_q, ys_d;
  logic [GROUPS-1:0] sh_s_q, sh_s_d, sh_d_q, sh_d_d, sh_t_q, sh_t_d;
  logic [GROUPS-1:0] sh_q_q, sh_q_d, sh_n_q, sh_n_d;
  logic [GROUPS-1:0] s_q, s_d, d_q, d_d, t_q, t_d, q_q, q_d, n_q, n_d;
  logic [WIDTH-1:0]  my_q, my_d;
  logic [WIDTH+1:0]  tmy_q, tmy_d;
  logic              enc_valid_q, enc_valid_d;
  logic              enc_upd_q, enc_upd_d;

  logic [XEW-1:0]    xe;
  logic [3:0]        win;
  logic              dig_s, dig_d, dig_t, dig_q, dig_n;
  logic [WIDTH+1:0]  y_ext;
  logic [WIDTH+1:0]  tmy_calc;

  assign load_ready = RST & (state_q == ST_IDLE) & ~clr;

  assign s         = s_q;
  assign d         = d_q;
  assign t         = t_q;
  assign q         = q_q;
  assign n         = n_q;
  assign my        = my_q;
  assign tmy       = tmy_q;
  assign enc_valid = enc_valid_q;
  assign enc_upd   = enc_upd_q;

  assign xe       = {{(XEW - WIDTH - 1){xs_q[WIDTH-1]}}, xs_q, 1'b0};
  assign y_ext    = {{2{ys_q[WIDTH-1]}}, ys_q};
  assign tmy_calc = y_ext + {y_ext[WIDTH:0], 1'b0};

  // Select the 4-bit window of the group currently being encoded
  always_comb begin
    win = 4'b0000;
    for (int k = 0; k < GROUPS; k++) begin
      if (g_q == k[GW-1:0]) win = xe[3*k +: 4];
    end
  end

  // Window to one-hot magnitude plus sign; 0000 and 1111 both encode zero
  always_comb begin
    dig_s = 1'b0;
    dig_d = 1'b0;
    dig_t = 1'b0;
    dig_q = 1'b0;
    dig_n = 1'b0;
    case (win)
      4'b0001, 4'b0010: dig_s = 1'b1;
      4'b0011, 4'b0100: dig_d = 1'b1;
      4'b0101, 4'b0110: dig_t = 1'b1;
      4'b0111:          dig_q = 1'b1;
      4'b1000:          begin dig_q = 1'b1; dig_n = 1'b1; end
      4'b1001, 4'b1010: begin dig_t = 1'b1; dig_n = 1'b1; end
      4'b1011, 4'b1100: begin dig_d = 1'b1; dig_n = 1'b1; end
      4'b1101, 4'b1110: begin dig_s = 1'b1; dig_n = 1'b1; end
      default: ;
    endcase
  end

  // Control FSM: capture, walk the groups into the shadow, then commit everything in one edge
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    sh_s_d      = sh_s_q;
    sh_d_d      = sh_d_q;
    sh_t_d      = sh_t_q;
    sh_q_d      = sh_q_q;
    sh_n_d      = sh_n_q;
    s_d         = s_q;
    d_d         = d_q;
    t_d         = t_q;
    q_d         = q_q;
    n_d         = n_q;
    my_d        = my_q;
    tmy_d       = tmy_q;
    enc_valid_d = enc_valid_q;
    enc_upd_d   = 1'b0;

    if (clr) begin
      state_d     = ST_IDLE;
      g_d         = '0;
      xs_d        = '0;
      ys_d        = '0;
      sh_s_d      = '0;
      sh_d_d      = '0;
      sh_t_d      = '0;
      sh_q_d      = '0;
      sh_n_d      = '0;
      s_d         = '0;
      d_d         = '0;
      t_d         = '0;
      q_d         = '0;
      n_d         = '0;
      my_d        = '0;
      tmy_d       = '0;
      enc_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            xs_d    = x;
            ys_d    = y;
            g_d     = '0;
            sh_s_d  = '0;
            sh_d_d  = '0;
            sh_t_d  = '0;
            sh_q_d  = '0;
            sh_n_d  = '0;
            state_d = ST_ENC;
          end
        end
        ST_ENC: begin
          for (int k = 0; k < GROUPS; k++) begin
            if (g_q == k[GW-1:0]) begin
              sh_s_d[k] = dig_s;
              sh_d_d[k] = dig_d;
              sh_t_d[k] = dig_t;
              sh_q_d[k] = dig_q;
              sh_n_d[k] = dig_n;
            end
          end
          if (g_q == G_LAST) begin
            g_d     = '0;
            state_d = ST_COMMIT;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          s_d         = sh_s_q;
          d_d         = sh_d_q;
          t_d         = sh_t_q;
          q_d         = sh_q_q;
          n_d         = sh_n_q;
          my_d        = ys_q;
          tmy_d       = tmy_calc;
          enc_valid_d = 1'b1;
          enc_upd_d   = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          g_d     = '0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      xs_q        <= '0;
      ys_q        <= '0;
      sh_s_q      <= '0;
      sh_d_q      <= '0;
      sh_t_q      <= '0;
      sh_q_q      <= '0;
      sh_n_q      <= '0;
      s_q         <= '0;
      d_q         <= '0;
      t_q         <= '0;
      q_q         <= '0;
      n_q         <= '0;
      my_q        <= '0;
      tmy_q       <= '0;
      enc_valid_q <= 1'b0;
      enc_upd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      sh_s_q      <= sh_s_d;
      sh_d_q      <= sh_d_d;
      sh_t_q      <= sh_t_d;
      sh_q_q      <= sh_q_d;
      sh_n_q      <= sh_n_d;
      s_q         <= s_d;
      d_q         <= d_d;
      t_q         <= t_d;
      q_q         <= q_d;
      n_q         <= n_d;
      my_q        <= my_d;
      tmy_q       <= tmy_d;
      enc_valid_q <= enc_valid_d;
      enc_upd_q   <= enc_upd_d;
    end
  end

endmodule

// File: tb/tb_booth_r8_frozen_enc.sv
// tb/tb_booth_r8_frozen_enc.sv - scoreboard bench for booth_r8_frozen_enc
module tb_booth_r8_frozen_enc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        clr = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [5:0]  s, d, t, q, n;
  logic [15:0] my;
  logic [17:0] tmy;
  logic        enc_valid;
  logic        enc_upd;

  typedef struct packed {
    logic [5:0]  s, d, t, q, n;
    logic [15:0] my;
    logic [17:0] tmy;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  booth_r8_frozen_enc #(.WIDTH(16), .GROUPS(6)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .load_valid(load_valid), .load_ready(load_ready),
    .x(x), .y(y), .s(s), .d(d), .t(t), .q(q), .n(n), .my(my), .tmy(tmy),
    .enc_valid(enc_valid), .enc_upd(enc_upd)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [5:0] es, ed, et, eq, en, input logic [15:0] emy, input logic [17:0] etmy);
    exp_t e;
    e.s = es; e.d = ed; e.t = et; e.q = eq; e.n = en; e.my = emy; e.tmy = etmy;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_digits"}, {s, d, t, q, n}, 64'd0);
    chk({nm, "_my"}, my, 64'd0);
    chk({nm, "_tmy"}, tmy, 64'd0);
    chk({nm, "_enc_valid"}, enc_valid, 64'd0);
    chk({nm, "_enc_upd"}, enc_upd, 64'd0);
  endtask

  // Offer a load and return 1ns after the accepting edge
  task automatic accept(input logic [15:0] xv, input logic [15:0] yv);
    int b = 0;
    @(negedge CLK);
    x = xv; y = yv; load_valid = 1'b1;
    while (!load_ready && b < 20) begin
      @(negedge CLK);
      b++;
    end
    chk("accept_ready", load_ready, 64'd1);
    @(posedge CLK);
    #1 load_valid = 1'b0;
  endtask

  // Count edges from the accept edge to the commit and check the one-cycle pulse
  task automatic wait_commit(input string nm);
    int  cnt  = 0;
    bit  seen = 0;
    while (cnt < 20 && !seen) begin
      @(posedge CLK);
      cnt++;
      #1;
      if (enc_upd) seen = 1;
    end
    chk({nm, "_latency"}, cnt, 64'd7);
    @(posedge CLK);
    #1;
    chk({nm, "_upd_pulse"}, enc_upd, 64'd0);
    chk({nm, "_valid_hold"}, enc_valid, 64'd1);
  endtask

  // Monitor: every commit pulse is matched against the oldest expected encoding
  always @(negedge CLK) begin
    if (enc_upd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_s", s, e.s);
        chk("mon_d", d, e.d);
        chk("mon_t", t, e.t);
        chk("mon_q", q, e.q);
        chk("mon_n", n, e.n);
        chk("mon_my", my, e.my);
        chk("mon_tmy", tmy, e.tmy);
        chk("mon_enc_valid", enc_valid, 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x1_rec;
    int          cnt;
    bit          seen;

    // reset state
    #1;
    chk_zero("reset");
    chk("reset_load_ready", load_ready, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1 chk("idle_load_ready", load_ready, 64'd1);

    // x=1, y=5
    push(6'b000001, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0005, 18'h0000F);
    accept(16'h0001, 16'h0005);
    wait_commit("x0001");
    x1_rec = {6'b000001, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0005, 18'h0000F};

    // x=4 with load_valid held while busy: outputs stay frozen until commit
    push(6'b000010, 6'b0, 6'b0, 6'b000001, 6'b000001, 16'h0003, 18'h00009);
    @(negedge CLK);
    x = 16'h0004; y = 16'h0003; load_valid = 1'b1;
    @(posedge CLK);
    #1;
    cnt = 0; seen = 0;
    while (cnt < 20 && !seen) begin
      @(posedge CLK);
      cnt++;
      #1;
      if (enc_upd) begin
        seen = 1;
        load_valid = 1'b0;
      end else begin
        chk("freeze_outputs", {s, d, t, q, n, my, tmy}, x1_rec);
        chk("busy_load_ready", load_ready, 64'd0);
      end
    end
    load_valid = 1'b0;
    chk("freeze_latency", cnt, 64'd7);
    repeat (3) @(posedge CLK);
    #1 chk("no_double_accept", load_ready, 64'd1);

    // x=FFFF, y=-1
    push(6'b000001, 6'b0, 6'b0, 6'b0, 6'b000001, 16'hFFFF, 18'h3FFFD);
    accept(16'hFFFF, 16'hFFFF);
    wait_commit("xFFFF");

    // x=3 -> +3 in group 0, y=7FFF
    push(6'b0, 6'b0, 6'b000001, 6'b0, 6'b0, 16'h7FFF, 18'h17FFD);
    accept(16'h0003, 16'h7FFF);
    wait_commit("x0003");

    // x=C -> -4 in group 0, +2 in group 1
    push(6'b0, 6'b000010, 6'b0, 6'b000001, 6'b000001, 16'h1234, 18'h0369C);
    accept(16'h000C, 16'h1234);
    wait_commit("x000C");

    // clr together with load_valid in IDLE
    @(negedge CLK);
    clr = 1'b1; load_valid = 1'b1; x = 16'h0001; y = 16'h0005;
    #1 chk("clr_idle_ready", load_ready, 64'd0);
    @(posedge CLK);
    #1;
    chk_zero("clr_idle");
    clr = 1'b0; load_valid = 1'b0;
    #1 chk("clr_idle_no_accept", load_ready, 64'd1);

    // x=8000, y=8000 -> -1 in top group
    push(6'b100000, 6'b0, 6'b0, 6'b0, 6'b100000, 16'h8000, 18'h28000);
    accept(16'h8000, 16'h8000);
    wait_commit("x8000");

    // clr at ENC g=3
    accept(16'hFFFF, 16'h0005);
    repeat (3) @(posedge CLK);
    #1 clr = 1'b1;
    @(posedge CLK);
    #1;
    chk_zero("clr_enc");
    clr = 1'b0;
    #1 chk("clr_enc_idle", load_ready, 64'd1);
    repeat (10) @(posedge CLK);

    // re-establish nonzero outputs, then async reset mid-ENC
    push(6'b000001, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0005, 18'h0000F);
    accept(16'h0001, 16'h0005);
    wait_commit("pre_rst");
    accept(16'h0003, 16'h7FFF);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    chk_zero("async_rst");
    chk("async_rst_ready", load_ready, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(posedge CLK);

    // fresh load after reset
    push(6'b000001, 6'b0, 6'b0, 6'b0, 6'b0, 16'h0005, 18'h0000F);
    accept(16'h0001, 16'h0005);
    wait_commit("post_rst");

    repeat (5) @(posedge CLK);
    #1 chk("queue_empty", exp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
